nd_tile_collector: RTL and testbench

- Upstream feeder for the nd-array index/permute stage.
- Accepts a serial stream of W-bit elements over a valid/ready handshake and packs them row-major into a ROWS x COLS unpacked tile.
- Presents each completed tile as one word, with a per-tile tag and a short-tile flag, over a second valid/ready handshake.
- Two tile banks (ping-pong) let streaming continue while the downstream stage holds a tile.

---
 rtl/nd_tile_collector_pkg.sv | 27 ++
 rtl/nd_tile_collector_if.sv | 31 +++
 rtl/nd_tile_collector_bank.sv | 61 ++++++
 rtl/nd_tile_collector.sv | 106 ++++++++++
 tb/tb_nd_tile_collector.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/nd_tile_collector_pkg.sv
// nd_tile_collector shared types and sizes.
// Tile geometry, bank states and pointer helpers.
package nd_tile_pkg;

  localparam int W      = 3;
  localparam int ROWS   = 6;
  localparam int COLS   = 4;
  localparam int TAG_W  = 3;
  localparam int TILE_N = ROWS * COLS;
  localparam int PTR_W  = $clog2(TILE_N);
  localparam int ROW_W  = $clog2(ROWS);
  localparam int COL_W  = $clog2(COLS);

  typedef enum logic [1:0] {
    EMPTY,
    FILLING,
    FULL
  } bank_st_e;

  typedef logic [W-1:0] tile_t [ROWS][COLS];
  typedef logic [PTR_W-1:0] ptr_t;

  function automatic logic is_last_slot(ptr_t p);
    return p == ptr_t'(TILE_N - 1);
  endfunction

endpackage

// File: rtl/nd_tile_collector_if.sv
// nd_tile_collector element-in / tile-out bus.
// master drives elements, slave is the collector.
interface nd_tile_if;
  import nd_tile_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_data;
  logic             in_last;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  tile_t            out_tile;
  logic [TAG_W-1:0] out_tag;
  logic             out_flag;

  modport master (
    output in_valid, in_data, in_last, in_tag,
    output out_ready,
    input  in_ready, out_valid, out_tile,
    input  out_tag, out_flag
  );

  modport slave (
    input  in_valid, in_data, in_last, in_tag,
    input  out_ready,
    output in_ready, out_valid, out_tile,
    output out_tag, out_flag
  );

endinterface

// File: rtl/nd_tile_collector_bank.sv
// One ping-pong tile bank: storage, tag, flag, state.
// Release wipes contents so short tiles read back zero.
module nd_tile_bank
  import nd_tile_pkg::*;
(
  input  logic             CLK,
  input  logic             ASYNCRESET,
  input  logic             i_wr,
  input  ptr_t             i_ptr,
  input  logic [W-1:0]     i_data,
  input  logic [TAG_W-1:0] i_tag,
  input  logic             i_close,
  input  logic             i_flag,
  input  logic             i_rel,
  output bank_st_e         o_state,
  output tile_t            o_tile,
  output logic [TAG_W-1:0] o_tag,
  output logic             o_flag
);

  bank_st_e         r_state;
  tile_t            r_tile;
  logic [TAG_W-1:0] r_tag;
  logic             r_flag;
  logic [ROW_W-1:0] w_row;
  logic [COL_W-1:0] w_col;

  assign w_row = ROW_W'(i_ptr / PTR_W'(COLS));
  assign w_col = COL_W'(i_ptr % PTR_W'(COLS));

  // Fill element by element, clear everything on release.
  always_ff @(posedge CLK or posedge ASYNCRESET) begin
    if (ASYNCRESET) begin
      r_state <= EMPTY;
      r_tile  <= '{default: '0};
      r_tag   <= '0;
      r_flag  <= 1'b0;
    end else if (i_rel) begin
      r_state <= EMPTY;
      r_tile  <= '{default: '0};
      r_tag   <= '0;
      r_flag  <= 1'b0;
    end else if (i_wr) begin
      r_tile[w_row][w_col] <= i_data;
      if (i_ptr == '0)
        r_tag <= i_tag;
      if (i_close) begin
        r_state <= FULL;
        r_flag  <= i_flag;
      end else begin
        r_state <= FILLING;
      end
    end
  end

  assign o_state = r_state;
  assign o_tile  = r_tile;
  assign o_tag   = r_tag;
  assign o_flag  = r_flag;

endmodule

// File: rtl/nd_tile_collector.sv
// Packs an element stream into ROWS x COLS tiles.
// Two banks ping-pong so filling overlaps the hold.
module nd_tile_collector
  import nd_tile_pkg::*;
(
  input  logic        CLK,
  input  logic        ASYNCRESET,
  nd_tile_if.slave    bus
);

  ptr_t             r_fill_ptr;
  logic             r_fill_bank;
  logic             r_head_bank;

  bank_st_e         w_st0;
  bank_st_e         w_st1;
  tile_t            w_tile0;
  tile_t            w_tile1;
  logic [TAG_W-1:0] w_tag0;
  logic [TAG_W-1:0] w_tag1;
  logic             w_flag0;
  logic             w_flag1;

  bank_st_e         w_fill_st;
  bank_st_e         w_head_st;
  logic             w_acc;
  logic             w_end;
  logic             w_close;
  logic             w_flag;
  logic             w_rel;

  assign w_fill_st = r_fill_bank ? w_st1 : w_st0;
  assign w_head_st = r_head_bank ? w_st1 : w_st0;

  assign bus.in_ready  = (w_fill_st != FULL);
  assign bus.out_valid = (w_head_st == FULL);

  assign w_acc   = bus.in_valid & bus.in_ready;
  assign w_end   = is_last_slot(r_fill_ptr);
  assign w_close = w_acc & (bus.in_last | w_end);
  assign w_flag  = bus.in_last & ~w_end;
  assign w_rel   = bus.out_valid & bus.out_ready;

  nd_tile_bank u_bank0 (
    .CLK        (CLK),
    .ASYNCRESET (ASYNCRESET),
    .i_wr       (w_acc & ~r_fill_bank),
    .i_ptr      (r_fill_ptr),
    .i_data     (bus.in_data),
    .i_tag      (bus.in_tag),
    .i_close    (w_close),
    .i_flag     (w_flag),
    .i_rel      (w_rel & ~r_head_bank),
    .o_state    (w_st0),
    .o_tile     (w_tile0),
    .o_tag      (w_tag0),
    .o_flag     (w_flag0)
  );

  nd_tile_bank u_bank1 (
    .CLK        (CLK),
    .ASYNCRESET (ASYNCRESET),
    .i_wr       (w_acc & r_fill_bank),
    .i_ptr      (r_fill_ptr),
    .i_data     (bus.in_data),
    .i_tag      (bus.in_tag),
    .i_close    (w_close),
    .i_flag     (w_flag),
    .i_rel      (w_rel & r_head_bank),
    .o_state    (w_st1),
    .o_tile     (w_tile1),
    .o_tag      (w_tag1),
    .o_flag     (w_flag1)
  );

  // Present the head bank; its registers hold while stalled.
  always_comb begin
    bus.out_tile = w_tile0;
    bus.out_tag  = w_tag0;
    bus.out_flag = w_flag0;
    if (r_head_bank) begin
      bus.out_tile = w_tile1;
      bus.out_tag  = w_tag1;
      bus.out_flag = w_flag1;
    end
  end

  // Advance fill pointer/bank on accept, head on release.
  always_ff @(posedge CLK or posedge ASYNCRESET) begin
    if (ASYNCRESET) begin
      r_fill_ptr  <= '0;
      r_fill_bank <= 1'b0;
      r_head_bank <= 1'b0;
    end else begin
      if (w_close) begin
        r_fill_ptr  <= '0;
        r_fill_bank <= ~r_fill_bank;
      end else if (w_acc) begin
        r_fill_ptr  <= r_fill_ptr + 1'b1;
      end
      if (w_rel)
        r_head_bank <= ~r_head_bank;
    end
  end

endmodule

// File: tb/tb_nd_tile_collector.sv
// Directed bench for nd_tile_collector.
// Table of tile streams plus multi-cycle sequences.
module tb_nd_tile_collector;
  import nd_tile_pkg::*;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  nd_tile_if bus ();

  nd_tile_collector dut (
    .CLK        (clk),
    .ASYNCRESET (rst),
    .bus        (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         n;
    bit         last;
    logic [2:0] tag;
    int         seed;
    int         exp_flag;
  } vec_t;

  vec_t tbl [5];

  task automatic chk(string nm, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s act=%0d exp=%0d", nm, act, exp);
    end
  endtask

  function automatic int pat(int k, int seed);
    return (k + seed) % 8;
  endfunction

  task automatic chk_tile(string nm, int n, int seed);
    int e;
    for (int k = 0; k < TILE_N; k++) begin
      e = (k < n) ? pat(k, seed) : 0;
      chk(nm, int'(bus.out_tile[k / COLS][k % COLS]), e);
    end
  endtask

  task automatic push(int d, bit last, int tag, bit ordy);
    int g;
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.in_data   = W'(d);
    bus.in_last   = last;
    bus.in_tag    = TAG_W'(tag);
    bus.out_ready = ordy;
    g = 0;
    while (!bus.in_ready && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (g >= 100)
      chk("push_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  initial begin
    vec_t v;
    int   acc;
    total = 0;
    bad   = 0;

    tbl[0] = '{24, 1'b0, 3'd5, 0, 0};
    tbl[1] = '{10, 1'b1, 3'd2, 3, 1};
    tbl[2] = '{1,  1'b1, 3'd1, 7, 1};
    tbl[3] = '{24, 1'b1, 3'd6, 1, 0};
    tbl[4] = '{5,  1'b1, 3'd3, 2, 1};

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.in_tag    = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_tag", bus.out_tag, 0);
    chk("rst_out_flag", bus.out_flag, 0);
    chk_tile("rst_tile", 0, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", bus.in_ready, 1);

    // table: one tile per record, drained immediately
    for (int i = 0; i < 5; i++) begin
      v = tbl[i];
      for (int k = 0; k < v.n; k++) begin
        if (k == v.n - 1)
          chk("pre_valid", bus.out_valid, 0);
        push(pat(k, v.seed),
             v.last && (k == v.n - 1),
             v.tag, 1'b1);
      end
      chk("vec_valid", bus.out_valid, 1);
      chk("vec_tag", bus.out_tag, v.tag);
      chk("vec_flag", bus.out_flag, v.exp_flag);
      chk_tile("vec_tile", v.n, v.seed);
      idle();
      @(posedge clk);
      #1;
      chk("vec_one_cycle", bus.out_valid, 0);
      chk("vec_in_ready", bus.in_ready, 1);
    end

    // back-pressure: both banks fill, then drain in order
    acc = 0;
    for (int c = 0; c < 72; c++) begin
      @(negedge clk);
      bus.in_valid  = 1'b1;
      bus.in_last   = 1'b0;
      bus.in_data   = W'(pat(acc % 24, acc / 24));
      bus.in_tag    = (acc < 24) ? 3'd3 : 3'd4;
      bus.out_ready = 1'b0;
      if (bus.in_ready)
        acc++;
    end
    idle();
    chk("bp_accepted", acc, 48);
    chk("bp_in_ready", bus.in_ready, 0);
    chk("bp_valid", bus.out_valid, 1);
    chk("bp_tag0", bus.out_tag, 3);
    chk_tile("bp_tile0", 24, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("bp_stable_tag", bus.out_tag, 3);
    chk_tile("bp_stable", 24, 0);
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_ready_after_rel", bus.in_ready, 1);
    chk("bp_valid1", bus.out_valid, 1);
    chk("bp_tag1", bus.out_tag, 4);
    chk_tile("bp_tile1", 24, 1);
    @(posedge clk);
    #1;
    chk("bp_drained", bus.out_valid, 0);

    // release of one bank in the cycle the other closes
    for (int k = 0; k < 24; k++)
      push(pat(k, 2), 1'b0, 1, 1'b0);
    for (int k = 0; k < 23; k++)
      push(pat(k, 5), 1'b0, 6, 1'b0);
    chk("sim_head_valid", bus.out_valid, 1);
    chk("sim_head_tag", bus.out_tag, 1);
    chk_tile("sim_head_tile", 24, 2);
    push(pat(23, 5), 1'b0, 6, 1'b1);
    chk("sim_valid", bus.out_valid, 1);
    chk("sim_tag", bus.out_tag, 6);
    chk("sim_flag", bus.out_flag, 0);
    chk_tile("sim_tile", 24, 5);
    idle();
    @(posedge clk);
    #1;
    chk("sim_drained", bus.out_valid, 0);
    for (int k = 0; k < 3; k++)
      push(pat(k, 1), k == 2, 4, 1'b0);
    chk("reuse_valid", bus.out_valid, 1);
    chk("reuse_flag", bus.out_flag, 1);
    chk("reuse_tag", bus.out_tag, 4);
    chk_tile("reuse_tile", 3, 1);
    idle();
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("reuse_drained", bus.out_valid, 0);

    // asynchronous reset with a held tile and a partial one
    for (int k = 0; k < 24; k++)
      push(pat(k, 3), 1'b0, 2, 1'b0);
    for (int k = 0; k < 7; k++)
      push(pat(k, 6), 1'b0, 5, 1'b0);
    idle();
    chk("ar_pre_valid", bus.out_valid, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_valid", bus.out_valid, 0);
    chk("ar_tag", bus.out_tag, 0);
    chk_tile("ar_tile", 0, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("ar_in_ready", bus.in_ready, 1);
    for (int k = 0; k < 24; k++) begin
      if (k == 23)
        chk("ar_pre_close", bus.out_valid, 0);
      push(pat(k, 4), 1'b0, 7, 1'b1);
    end
    chk("ar_new_valid", bus.out_valid, 1);
    chk("ar_new_tag", bus.out_tag, 7);
    chk("ar_new_flag", bus.out_flag, 0);
    chk_tile("ar_new_tile", 24, 4);
    idle();
    @(posedge clk);
    #1;
    chk("ar_drained", bus.out_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
